// File: rtl/axi_rd_arbiter_512_if.sv
// Bundle of the shared AXI4 read channel: N_REQ requester-side AR/R ports and
// the single DDR-side AR/R port. The arbiter uses the master view.
interface axi_rd_arbiter_512_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]    req_ar_valid;
  logic [32*N_REQ-1:0] req_ar_addr;
  logic [8*N_REQ-1:0]  req_ar_len;
  logic [N_REQ-1:0]    req_ar_ready;
  logic [N_REQ-1:0]    req_r_valid;
  logic [511:0]        req_r_data;
  logic                req_r_last;
  logic [N_REQ-1:0]    req_r_ready;
  logic                m_ar_valid;
  logic [31:0]         m_ar_addr;
  logic [7:0]          m_ar_len;
  logic                m_ar_ready;
  logic                m_r_valid;
  logic [511:0]        m_r_data;
  logic                m_r_last;
  logic                m_r_ready;

  modport master (
    input  req_ar_valid, req_ar_addr, req_ar_len, req_r_ready,
    input  m_ar_ready, m_r_valid, m_r_data, m_r_last,
    output req_ar_ready, req_r_valid, req_r_data, req_r_last,
    output m_ar_valid, m_ar_addr, m_ar_len, m_r_ready
  );

  modport slave (
    output req_ar_valid, req_ar_addr, req_ar_len, req_r_ready,
    output m_ar_ready, m_r_valid, m_r_data, m_r_last,
    input  req_ar_ready, req_r_valid, req_r_data, req_r_last,
    input  m_ar_valid, m_ar_addr, m_ar_len, m_r_ready
  );
endinterface

// File: rtl/axi_rd_arbiter_512.sv
// Round-robin arbiter sharing one 512-bit AXI4 read channel between N_REQ read
// masters; one outstanding burst, whose R beats are routed back to the owner only.
module axi_rd_arbiter_512 #(
  parameter int N_REQ = 2
) (
  input  logic                 axi_clk,
  input  logic                 rstn,
  axi_rd_arbiter_512_if.master io_axi,
  output logic [1:0]           o_grant,
  output logic                 o_busy,
  output logic                 o_err_len
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [1:0] GRANT_RST = 2'(N_REQ - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_grant;
  logic             r_ar_valid;
  logic [31:0]      r_ar_addr;
  logic [7:0]       r_ar_len;
  logic [8:0]       r_beat_cnt;
  logic             r_err_len;
  logic             w_pick_vld;
  logic [1:0]       w_pick_idx;
  logic [31:0]      w_pick_addr;
  logic [7:0]       w_pick_len;
  int               w_dist;
  int               w_best_dist;
  logic             w_take;
  logic             w_sel_r_ready;
  logic             w_ar_hs;
  logic             w_r_hs;
  logic             w_cnt_at_len;
  logic [N_REQ-1:0] w_ar_ready;
  logic [N_REQ-1:0] w_r_valid;

  // Round-robin pick: the valid requester closest after r_grant wins.
  always_comb begin
    w_pick_vld  = 1'b0;
    w_pick_idx  = r_grant;
    w_best_dist = N_REQ;
    w_dist      = 0;
    w_take      = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      w_dist      = (i + 2 * N_REQ - int'(r_grant) - 1) % N_REQ;
      w_take      = io_axi.req_ar_valid[i] && (w_dist < w_best_dist);
      w_pick_vld  = w_pick_vld | w_take;
      w_pick_idx  = w_take ? 2'(i) : w_pick_idx;
      w_best_dist = w_take ? w_dist : w_best_dist;
    end
  end

  // Per-requester muxing of the picked request and steering of the granted handshakes.
  always_comb begin
    w_pick_addr   = 32'd0;
    w_pick_len    = 8'd0;
    w_sel_r_ready = 1'b0;
    w_ar_ready    = {N_REQ{1'b0}};
    w_r_valid     = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      w_pick_addr   = (w_pick_idx == 2'(i)) ? io_axi.req_ar_addr[32*i +: 32] : w_pick_addr;
      w_pick_len    = (w_pick_idx == 2'(i)) ? io_axi.req_ar_len[8*i +: 8] : w_pick_len;
      w_sel_r_ready = (r_grant == 2'(i)) ? io_axi.req_r_ready[i] : w_sel_r_ready;
      w_ar_ready[i] = (r_state == ST_ADDR) && (r_grant == 2'(i)) && io_axi.m_ar_ready;
      w_r_valid[i]  = (r_state == ST_DATA) && (r_grant == 2'(i)) && io_axi.m_r_valid;
    end
  end

  assign w_ar_hs      = (r_state == ST_ADDR) && io_axi.m_ar_ready;
  assign w_r_hs       = (r_state == ST_DATA) && io_axi.m_r_valid && w_sel_r_ready;
  assign w_cnt_at_len = (r_beat_cnt == {1'b0, r_ar_len});

  // State register.
  always_ff @(posedge axi_clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = w_pick_vld ? ST_ADDR : ST_IDLE;
      ST_ADDR: w_state_nxt = w_ar_hs ? ST_DATA : ST_ADDR;
      ST_DATA: w_state_nxt = (w_r_hs && io_axi.m_r_last) ? ST_IDLE : ST_DATA;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // AR latch, beat counter and sticky length check; r_grant also serves as last_grant.
  always_ff @(posedge axi_clk) begin
    if (!rstn) begin
      r_grant    <= GRANT_RST;
      r_ar_valid <= 1'b0;
      r_ar_addr  <= 32'd0;
      r_ar_len   <= 8'd0;
      r_beat_cnt <= 9'd0;
      r_err_len  <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_pick_vld) begin
      r_grant    <= w_pick_idx;
      r_ar_valid <= 1'b1;
      r_ar_addr  <= w_pick_addr;
      r_ar_len   <= w_pick_len;
    end else if (w_ar_hs) begin
      r_ar_valid <= 1'b0;
      r_beat_cnt <= 9'd0;
    end else if (w_r_hs) begin
      // Counter holds beats already accepted, so it equals len on the final beat.
      if (r_beat_cnt != 9'd511) begin
        r_beat_cnt <= r_beat_cnt + 9'd1;
      end
      if (io_axi.m_r_last ^ w_cnt_at_len) begin
        r_err_len <= 1'b1;
      end
    end
  end

  assign io_axi.m_ar_valid   = r_ar_valid;
  assign io_axi.m_ar_addr    = r_ar_addr;
  assign io_axi.m_ar_len     = r_ar_len;
  assign io_axi.m_r_ready    = (r_state == ST_DATA) && w_sel_r_ready;
  assign io_axi.req_ar_ready = w_ar_ready;
  assign io_axi.req_r_valid  = w_r_valid;
  assign io_axi.req_r_data   = io_axi.m_r_data;
  assign io_axi.req_r_last   = io_axi.m_r_last;
  assign o_grant             = r_grant;
  assign o_busy              = (r_state != ST_IDLE);
  assign o_err_len           = r_err_len;
endmodule

// File: tb/tb_axi_rd_arbiter_512.sv
// Directed bench for axi_rd_arbiter_512 with two requesters: reset, single
// burst, round-robin contention, backpressure, length errors, isolation, mid-burst reset.
module tb_axi_rd_arbiter_512;
  localparam logic [31:0] ADDR0 = 32'h0010_0000;
  localparam logic [31:0] ADDR1 = 32'h0020_0040;

  logic       axi_clk;
  logic       rstn;
  logic [1:0] o_grant;
  logic       o_busy;
  logic       o_err_len;
  int         errors;
  int         checks;

  axi_rd_arbiter_512_if #(.N_REQ(2)) bus ();

  axi_rd_arbiter_512 #(.N_REQ(2)) dut (
    .axi_clk   (axi_clk),
    .rstn      (rstn),
    .io_axi    (bus),
    .o_grant   (o_grant),
    .o_busy    (o_busy),
    .o_err_len (o_err_len)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  task automatic apply_reset();
    rstn             = 1'b0;
    bus.req_ar_valid = 2'b00;
    bus.m_r_valid    = 1'b0;
    bus.m_r_last     = 1'b0;
    bus.m_ar_ready   = 1'b1;
    bus.req_r_ready  = 2'b11;
    repeat (2) @(negedge axi_clk);
    rstn = 1'b1;
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the negedge of the first DATA cycle.
  task automatic ar_phase(input logic [1:0] mask, input logic [1:0] drop,
                          output logic [1:0] g, output logic [31:0] a, output logic [7:0] l,
                          output logic [1:0] rdy, output logic arv);
    bus.req_ar_valid = mask;
    @(negedge axi_clk);
    #1;
    g   = o_grant;
    a   = bus.m_ar_addr;
    l   = bus.m_ar_len;
    rdy = bus.req_ar_ready;
    arv = bus.m_ar_valid;
    bus.req_ar_valid = bus.req_ar_valid & ~drop;
    @(negedge axi_clk);
  endtask

  // Drives n back-to-back beats; returns at the negedge after the last one.
  task automatic data_phase(input int n, input int last_at, output int pulses,
                            output logic [1:0] vseen, output int data_bad);
    logic [31:0] w;
    pulses   = 0;
    vseen    = 2'b00;
    data_bad = 0;
    for (int b = 0; b < n; b++) begin
      if (b > 0) @(negedge axi_clk);
      w             = 32'hD000_0000 + 32'(b);
      bus.m_r_valid = 1'b1;
      bus.m_r_data  = {16{w}};
      bus.m_r_last  = (b + 1 == last_at);
      #1;
      if ((bus.req_r_valid != 2'b00) && bus.m_r_ready) pulses++;
      vseen = vseen | bus.req_r_valid;
      if ((bus.req_r_data !== {16{w}}) || (bus.req_r_last !== (b + 1 == last_at))) data_bad++;
    end
    @(negedge axi_clk);
    bus.m_r_valid = 1'b0;
    bus.m_r_last  = 1'b0;
  endtask

  task automatic test_reset();
    rstn             = 1'b0;
    bus.req_ar_valid = 2'b11;
    bus.req_ar_addr  = {ADDR1, ADDR0};
    bus.req_ar_len   = {8'd3, 8'd3};
    bus.req_r_ready  = 2'b11;
    bus.m_ar_ready   = 1'b1;
    bus.m_r_valid    = 1'b1;
    bus.m_r_data     = {16{32'h1234_5678}};
    bus.m_r_last     = 1'b1;
    repeat (2) @(negedge axi_clk);
    #1;
    checks++; if (bus.m_ar_valid !== 1'b0) begin errors++; $display("FAIL rst_m_ar_valid: got %0b want 0", bus.m_ar_valid); end
    checks++; if (bus.m_ar_addr !== 32'd0) begin errors++; $display("FAIL rst_m_ar_addr: got %0h want 0", bus.m_ar_addr); end
    checks++; if (bus.m_ar_len !== 8'd0) begin errors++; $display("FAIL rst_m_ar_len: got %0d want 0", bus.m_ar_len); end
    checks++; if (bus.m_r_ready !== 1'b0) begin errors++; $display("FAIL rst_m_r_ready: got %0b want 0", bus.m_r_ready); end
    checks++; if (bus.req_ar_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ar_ready: got %0b want 00", bus.req_ar_ready); end
    checks++; if (bus.req_r_valid !== 2'b00) begin errors++; $display("FAIL rst_req_r_valid: got %0b want 00", bus.req_r_valid); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", o_busy); end
    checks++; if (o_err_len !== 1'b0) begin errors++; $display("FAIL rst_err_len: got %0b want 0", o_err_len); end
    checks++; if (o_grant !== 2'd1) begin errors++; $display("FAIL rst_grant: got %0d want 1", o_grant); end
    checks++; if (bus.req_r_data !== {16{32'h1234_5678}}) begin errors++; $display("FAIL rst_r_data_pass: got %0h want 12345678 repeated", bus.req_r_data[31:0]); end
    checks++; if (bus.req_r_last !== 1'b1) begin errors++; $display("FAIL rst_r_last_pass: got %0b want 1", bus.req_r_last); end
  endtask

  task automatic test_single();
    logic [1:0] g, rdy, vs;
    logic [31:0] a;
    logic [7:0] l;
    logic arv;
    int p, bad;
    apply_reset();
    bus.req_ar_len = {8'd3, 8'd3};
    ar_phase(2'b01, 2'b01, g, a, l, rdy, arv);
    checks++; if (arv !== 1'b1) begin errors++; $display("FAIL single_arvalid: got %0b want 1", arv); end
    checks++; if (a !== ADDR0) begin errors++; $display("FAIL single_addr: got %0h want %0h", a, ADDR0); end
    checks++; if (l !== 8'd3) begin errors++; $display("FAIL single_len: got %0d want 3", l); end
    checks++; if (rdy !== 2'b01) begin errors++; $display("FAIL single_ar_ready: got %0b want 01", rdy); end
    checks++; if (g !== 2'd0) begin errors++; $display("FAIL single_grant: got %0d want 0", g); end
    #1;
    checks++; if (bus.m_ar_valid !== 1'b0) begin errors++; $display("FAIL single_arvalid_drop: got %0b want 0", bus.m_ar_valid); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL single_busy_data: got %0b want 1", o_busy); end
    data_phase(4, 4, p, vs, bad);
    checks++; if (p !== 4) begin errors++; $display("FAIL single_pulses: got %0d want 4", p); end
    checks++; if (vs !== 2'b01) begin errors++; $display("FAIL single_rvalid_mask: got %0b want 01", vs); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL single_rdata: got %0d bad beats want 0", bad); end
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %0b want 0", o_busy); end
    checks++; if (o_err_len !== 1'b0) begin errors++; $display("FAIL single_err_len: got %0b want 0", o_err_len); end
  endtask

  task automatic test_contention();
    logic [1:0] g, rdy, vs;
    logic [31:0] a;
    logic [7:0] l;
    logic arv;
    int p, bad;
    logic [1:0] want_g [4] = '{2'd0, 2'd1, 2'd0, 2'd1};
    logic [1:0] masks [4]  = '{2'b11, 2'b10, 2'b11, 2'b10};
    logic [1:0] drops [4]  = '{2'b01, 2'b10, 2'b01, 2'b10};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      ar_phase(masks[i], drops[i], g, a, l, rdy, arv);
      checks++; if (g !== want_g[i]) begin errors++; $display("FAIL rr_grant_%0d: got %0d want %0d", i, g, want_g[i]); end
      checks++; if (a !== ((want_g[i] == 2'd0) ? ADDR0 : ADDR1)) begin errors++; $display("FAIL rr_addr_%0d: got %0h", i, a); end
      checks++; if (arv !== 1'b1) begin errors++; $display("FAIL rr_arvalid_t2_%0d: got %0b want 1", i, arv); end
      data_phase(4, 4, p, vs, bad);
      checks++; if (p !== 4) begin errors++; $display("FAIL rr_pulses_%0d: got %0d want 4", i, p); end
      #1;
      checks++; if (bus.m_ar_valid !== 1'b0) begin errors++; $display("FAIL rr_arvalid_t1_%0d: got %0b want 0", i, bus.m_ar_valid); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w;
    logic rdy;
    int bi;
    apply_reset();
    bus.req_ar_len   = {8'd3, 8'd3};
    bus.m_ar_ready   = 1'b0;
    bus.req_ar_valid = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(negedge axi_clk);
      #1;
      checks++; if (bus.m_ar_valid !== 1'b1) begin errors++; $display("FAIL bp_arvalid_%0d: got %0b want 1", i, bus.m_ar_valid); end
      checks++; if (bus.m_ar_addr !== ADDR0) begin errors++; $display("FAIL bp_addr_%0d: got %0h want %0h", i, bus.m_ar_addr, ADDR0); end
      checks++; if (bus.req_ar_ready !== 2'b00) begin errors++; $display("FAIL bp_ar_ready_%0d: got %0b want 00", i, bus.req_ar_ready); end
    end
    bus.m_ar_ready   = 1'b1;
    bus.req_ar_valid = 2'b00;
    #1;
    checks++; if (bus.req_ar_ready !== 2'b01) begin errors++; $display("FAIL bp_ar_ready_hs: got %0b want 01", bus.req_ar_ready); end
    @(negedge axi_clk);
    bi = 0;
    for (int k = 0; (k < 20) && (bi < 4); k++) begin
      if (k > 0) @(negedge axi_clk);
      rdy             = (k % 2 == 0);
      w               = 32'hB000_0000 + 32'(bi);
      bus.req_r_ready = {1'b1, rdy};
      bus.m_r_valid   = 1'b1;
      bus.m_r_data    = {16{w}};
      bus.m_r_last    = (bi == 3);
      #1;
      checks++; if (bus.m_r_ready !== rdy) begin errors++; $display("FAIL bp_r_ready_%0d: got %0b want %0b", k, bus.m_r_ready, rdy); end
      checks++; if (bus.req_r_valid !== 2'b01) begin errors++; $display("FAIL bp_r_valid_%0d: got %0b want 01", k, bus.req_r_valid); end
      if (rdy) bi++;
    end
    @(negedge axi_clk);
    bus.m_r_valid   = 1'b0;
    bus.m_r_last    = 1'b0;
    bus.req_r_ready = 2'b11;
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL bp_busy_end: got %0b want 0", o_busy); end
    checks++; if (o_err_len !== 1'b0) begin errors++; $display("FAIL bp_err_len: got %0b want 0", o_err_len); end
  endtask

  task automatic test_len_err();
    logic [1:0] g, rdy, vs;
    logic [31:0] a;
    logic [7:0] l;
    logic arv;
    int p, bad;
    apply_reset();
    bus.req_ar_len = {8'd3, 8'd3};
    ar_phase(2'b01, 2'b01, g, a, l, rdy, arv);
    data_phase(2, 2, p, vs, bad);
    #1;
    checks++; if (o_err_len !== 1'b1) begin errors++; $display("FAIL lerr_short: got %0b want 1", o_err_len); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL lerr_short_idle: got %0b want 0", o_busy); end
    ar_phase(2'b01, 2'b01, g, a, l, rdy, arv);
    checks++; if (g !== 2'd0) begin errors++; $display("FAIL lerr_regrant: got %0d want 0", g); end
    data_phase(4, 4, p, vs, bad);
    #1;
    checks++; if (o_err_len !== 1'b1) begin errors++; $display("FAIL lerr_sticky: got %0b want 1", o_err_len); end
    apply_reset();
    #1;
    checks++; if (o_err_len !== 1'b0) begin errors++; $display("FAIL lerr_cleared: got %0b want 0", o_err_len); end
    bus.req_ar_len = {8'd3, 8'd1};
    ar_phase(2'b01, 2'b01, g, a, l, rdy, arv);
    for (int b = 0; b < 3; b++) begin
      if (b > 0) @(negedge axi_clk);
      bus.m_r_valid = 1'b1;
      bus.m_r_last  = (b == 2);
      #1;
      if (b == 1) begin
        checks++; if (o_err_len !== 1'b0) begin errors++; $display("FAIL lerr_long_early: got %0b want 0", o_err_len); end
      end
      if (b == 2) begin
        checks++; if (o_err_len !== 1'b1) begin errors++; $display("FAIL lerr_long: got %0b want 1", o_err_len); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL lerr_long_stay: got %0b want 1", o_busy); end
      end
    end
    @(negedge axi_clk);
    bus.m_r_valid = 1'b0;
    bus.m_r_last  = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL lerr_long_end: got %0b want 0", o_busy); end
  endtask

  task automatic test_isolation();
    logic [1:0] g, rdy, vs;
    logic [31:0] a;
    logic [7:0] l;
    logic arv;
    int p, bad;
    apply_reset();
    bus.req_ar_len = {8'd3, 8'd3};
    ar_phase(2'b10, 2'b10, g, a, l, rdy, arv);
    checks++; if (g !== 2'd1) begin errors++; $display("FAIL iso_grant1: got %0d want 1", g); end
    checks++; if (a !== ADDR1) begin errors++; $display("FAIL iso_addr1: got %0h want %0h", a, ADDR1); end
    bus.req_ar_valid[0] = 1'b1;
    data_phase(4, 4, p, vs, bad);
    checks++; if (vs !== 2'b10) begin errors++; $display("FAIL iso_rvalid_mask: got %0b want 10", vs); end
    checks++; if (p !== 4) begin errors++; $display("FAIL iso_pulses: got %0d want 4", p); end
    #1;
    checks++; if (o_grant !== 2'd1) begin errors++; $display("FAIL iso_grant_hold: got %0d want 1", o_grant); end
    ar_phase(2'b01, 2'b01, g, a, l, rdy, arv);
    checks++; if (g !== 2'd0) begin errors++; $display("FAIL iso_grant0: got %0d want 0", g); end
    data_phase(4, 4, p, vs, bad);
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] g, rdy, vs;
    logic [31:0] a;
    logic [7:0] l;
    logic arv;
    int p, bad;
    apply_reset();
    bus.req_ar_len = {8'd3, 8'd3};
    ar_phase(2'b01, 2'b01, g, a, l, rdy, arv);
    data_phase(4, 4, p, vs, bad);
    ar_phase(2'b10, 2'b10, g, a, l, rdy, arv);
    data_phase(4, 4, p, vs, bad);
    ar_phase(2'b01, 2'b01, g, a, l, rdy, arv);
    checks++; if (g !== 2'd0) begin errors++; $display("FAIL rmid_grant_before: got %0d want 0", g); end
    bus.m_r_valid = 1'b1;
    bus.m_r_data  = {16{32'hC0DE_0001}};
    @(negedge axi_clk);
    bus.m_r_data = {16{32'hC0DE_0002}};
    rstn         = 1'b0;
    @(negedge axi_clk);
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %0b want 0", o_busy); end
    checks++; if (o_grant !== 2'd1) begin errors++; $display("FAIL rmid_grant: got %0d want 1", o_grant); end
    checks++; if (bus.m_ar_addr !== 32'd0) begin errors++; $display("FAIL rmid_addr: got %0h want 0", bus.m_ar_addr); end
    checks++; if (bus.m_ar_len !== 8'd0) begin errors++; $display("FAIL rmid_len: got %0d want 0", bus.m_ar_len); end
    checks++; if (bus.m_r_ready !== 1'b0) begin errors++; $display("FAIL rmid_r_ready: got %0b want 0", bus.m_r_ready); end
    checks++; if (bus.req_r_valid !== 2'b00) begin errors++; $display("FAIL rmid_r_valid: got %0b want 00", bus.req_r_valid); end
    bus.m_r_valid = 1'b0;
    rstn          = 1'b1;
    ar_phase(2'b11, 2'b01, g, a, l, rdy, arv);
    checks++; if (g !== 2'd0) begin errors++; $display("FAIL rmid_priority: got %0d want 0", g); end
    data_phase(4, 4, p, vs, bad);
    bus.req_ar_valid = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_len_err();
    test_isolation();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_rd_arbiter_512.md
# axi_rd_arbiter_512

Round-robin arbiter that shares one 512-bit AXI4 read channel (AR + R) to the DDR controller between N_REQ frame-buffer read masters, such as several line-fetch address decoders. The block grants one requester at a time, forwards its AR request, and routes the returning R burst back to that requester only. It sits in the axi_clk domain between the read-address decoders and the DDR AXI port.

## Interface
- N_REQ, 2: number of requesters, legal 2..4.
- axi_clk  in  1  clock for all logic.
- rstn  in  1  reset: rstn, synchronous, active-low; clock axi_clk.
- req_ar_valid  in  N_REQ  per-requester AR valid.
- req_ar_addr  in  32*N_REQ  per-requester AR address; requester i uses bits [32*i+:32].
- req_ar_len  in  8*N_REQ  per-requester AXI burst length (beats−1).
- req_ar_ready  out  N_REQ  per-requester AR ready.
- req_r_valid  out  N_REQ  per-requester R valid.
- req_r_data  out  512  R data, broadcast to all requesters.
- req_r_last  out  1  R last, broadcast.
- req_r_ready  in  N_REQ  per-requester R ready.
- m_ar_valid  out  1  to DDR.
- m_ar_addr  out  32  to DDR.
- m_ar_len  out  8  to DDR.
- m_ar_ready  in  1  from DDR.
- m_r_valid  in  1  from DDR.
- m_r_data  in  512  from DDR.
- m_r_last  in  1  from DDR.
- m_r_ready  out  1  to DDR.
- grant  out  2  index of the current or last granted requester.
- busy  out  1  high in states ADDR and DATA.
- err_len  out  1  sticky burst-length mismatch flag.

## Operation
- FSM states: IDLE, ADDR, DATA. Only one outstanding transaction at a time.
- **IDLE**
  - If any req_ar_valid is high, select the first asserted requester searching from (last_grant+1) mod N_REQ upward, wrapping around.
  - Latch that requester's addr and len into m_ar_addr and m_ar_len, set grant, assert m_ar_valid, and go to ADDR.
- **ADDR**
  - m_ar_valid, m_ar_addr and m_ar_len are held stable.
  - req_ar_ready[grant] = m_ar_ready (combinational). All other req_ar_ready bits are 0.
  - On m_ar_ready: deassert m_ar_valid, clear the beat counter, and go to DATA.
- **DATA**
  - req_r_valid[grant] = m_r_valid. Other req_r_valid bits are 0.
  - m_r_ready = req_r_ready[grant].
  - req_r_data and req_r_last pass through combinationally.
  - Beat counter (9 bits) increments on each m_r_valid & m_r_ready.
  - On the beat that has m_r_last: if counter ≠ latched len, set err_len. Then last_grant ← grant and go to IDLE.
  - If the counter reaches latched len and that beat lacks m_r_last, set err_len and stay in DATA until m_r_last arrives. The counter saturates at 511.
- Requester changes:
  - A requester dropping req_ar_valid while in ADDR is an AXI violation. The latched request is still issued.
  - Requests arriving outside IDLE wait; nothing is queued.
- Reset: state IDLE; last_grant = N_REQ−1, so requester 0 has first priority. grant = N_REQ−1. err_len cleared.

## Timing
- Reset values of outputs: m_ar_valid 0, m_ar_addr 0, m_ar_len 0, m_r_ready 0, all req_ar_ready 0, all req_r_valid 0, busy 0, err_len 0, grant N_REQ−1. req_r_data and req_r_last follow m_r_* combinationally.
- Cycle numbering for a single request:
  - req_ar_valid seen in IDLE at cycle c → m_ar_valid high from c+1.
  - With m_ar_ready high at c+1, the AR handshake completes at c+1, req_ar_ready pulses for exactly that cycle, and DATA starts at c+2.
- R path has zero latency: valid, ready, data and last are combinational through the mux.
- Last beat accepted at cycle t → IDLE at t+1 → the next m_ar_valid earliest at t+2.
- Simultaneous requests in IDLE: the round-robin pick wins. The other requester is served on the next IDLE pass.
- Reset asserted mid-burst: the FSM aborts at the next edge. Remaining DDR beats are not drained by this block; the DDR side must be reset together with it.

## Test plan
- **Single request:** req0 requests addr 0x0010_0000, len 3, with m_ar_ready tied 1, then 4 R beats with last on beat 4 → m_ar_addr = 0x0010_0000 and m_ar_len = 3 at c+1; req_r_valid[0] pulses 4 times; err_len stays 0; busy low at t+1.
- **Contention:** req0 and req1 valid together from reset → req0 granted first, req1 second; then both again → req0 again (round-robin alternates 0,1,0,1).
- **Backpressure:** m_ar_ready held low 5 cycles → m_ar_valid and m_ar_addr stable, req_ar_ready stays 0. Then req_r_ready[grant] toggles → m_r_ready mirrors it and no beat is lost (counter = 4 at last).
- **Length error:** len 3 but m_r_last on beat 2 → err_len = 1 (sticky), FSM returns to IDLE. Separately, len 1 with last on beat 3 → err_len = 1, FSM stays in DATA until beat 3.
- **Isolation:** during a req1 burst, req0 asserts req_r_ready=1 → req_r_valid[0] stays 0 throughout, and req0 is granted only after req1's last beat.
- **Reset mid-burst:** rstn low during DATA beat 2 → the next edge gives IDLE with all outputs at reset values; after release, req0 has priority.
